// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring-subtract step per clock.
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_en
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t              state;
  logic [CW-1:0]       count;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   rd;
  logic                neg;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;
  logic                sa, sb, neg_in;
  logic [DATA_W-1:0]   ma, mb, div_val, fin;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod;
  always_comb begin
    sa = op_a[DATA_W-1] & (funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11);
    sb = op_b[DATA_W-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    ma = sa ? -op_a : op_a;
    mb = sb ? -op_b : op_b;
    // a zero divisor keeps the all-ones quotient unsigned; remainder follows the dividend
    neg_in = funct3[2] ? (funct3[1] ? sa : (sa ^ sb) & |op_b) : sa ^ sb;
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*DATA_W-1:DATA_W-1];
    div_diff = div_shift - {1'b0, opnd};
    prod = neg ? -acc : acc;
    div_val = op[1] ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
    fin = op[2] ? (neg ? -div_val : div_val) : (op[1:0] == 2'b00 ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]);
  end
  // acc holds {hi, lo} product for multiply and {remainder, quotient} for divide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op <= '0;
      rd <= '0;
      neg <= 1'b0;
      opnd <= '0;
      acc <= '0;
      done <= 1'b0;
      result <= '0;
      wb_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          count <= '0;
          op <= funct3;
          rd <= rd_addr;
          neg <= neg_in;
          opnd <= funct3[2] ? mb : ma;
          acc <= {{DATA_W{1'b0}}, funct3[2] ? ma : mb};
        end
        CALC: begin
          count <= count + 1'b1;
          acc <= op[2] ? (div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                           : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1})
                       : {mul_sum, acc[DATA_W-1:1]};
          if (count == CW'(DATA_W - 1)) state <= FIN;
        end
        default: begin
          state <= IDLE;
          result <= fin;
          wb_addr <= rd;
          done <= 1'b1;
        end
      endcase
    end
  end
  assign busy = state != IDLE;
  assign wb_en = done & |wb_addr;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic [4:0] rd_addr = 0;
  logic busy, done, wb_en;
  logic [31:0] result;
  logic [4:0] wb_addr;
  int n_vec = 0, n_err = 0, cyc = 0, t0 = 0;

  muldiv_unit dut (.clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
                   .rd_addr(rd_addr), .busy(busy), .done(done), .result(result), .wb_addr(wb_addr), .wb_en(wb_en));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic ovf;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_addr = rd; start = 1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_addr = 5'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    busy_ok = 1; lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (!busy) busy_ok = 0;
      @(posedge clk); #1;
      if (done) begin
        lat = cyc - t0;
        if (busy) busy_ok = 0;
        break;
      end
    end
  endtask

  task automatic exec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      output int lat, output bit bok, output logic [31:0] res, output logic [4:0] wa, output logic we);
    issue(f, a, b, rd);
    wait_done(lat, bok);
    res = result; wa = wb_addr; we = wb_en;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, wb_en, result, wb_addr} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b wb_en=%b result=%h wb_addr=%0d, expected all zero",
               busy, done, wb_en, result, wb_addr);
    end
    @(negedge clk) reset = 0;
  endtask

  typedef struct {logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;

  task automatic test_directed();
    vec_t dv[14] = '{
      '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
      '{3'd5, 32'd100, 32'd7, 32'd14},
      '{3'd7, 32'd100, 32'd7, 32'd2},
      '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF},
      '{3'd7, 32'd5, 32'd0, 32'd5},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
      '{3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF},
      '{3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9}};
    int lat; bit bok; logic [31:0] res; logic [4:0] wa, rd; logic we;
    for (int i = 0; i < 14; i++) begin
      rd = (i == 0) ? 5'd5 : 5'(i + 1);
      exec(dv[i].f, dv[i].a, dv[i].b, rd, lat, bok, res, wa, we);
      n_vec++;
      if (lat !== 33 || !bok) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d busy_ok=%0b, expected 33 busy_ok=1", i, lat, bok);
      end
      n_vec++;
      if (res !== dv[i].r) begin
        n_err++;
        $display("FAIL dir%0d_result f=%0d a=%h b=%h: got %h, expected %h", i, dv[i].f, dv[i].a, dv[i].b, res, dv[i].r);
      end
      n_vec++;
      if (wa !== rd || we !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_wb: got addr=%0d en=%b, expected addr=%0d en=1", i, wa, we, rd);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit bok; logic [31:0] res, a, b, exp; logic [4:0] wa, rd; logic [2:0] f; logic we;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom); a = pick(); b = pick(); rd = 5'($urandom);
      exp = model(f, a, b);
      exec(f, a, b, rd, lat, bok, res, wa, we);
      n_vec++;
      if (lat !== 33 || !bok || res !== exp || wa !== rd || we !== (rd != 0)) begin
        n_err++;
        $display("FAIL rnd%0d f=%0d a=%h b=%h rd=%0d: got lat=%0d busy_ok=%0b res=%h addr=%0d en=%b, expected lat=33 busy_ok=1 res=%h addr=%0d en=%b",
                 i, f, a, b, rd, lat, bok, res, wa, we, exp, rd, rd != 0);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    int lat; bit bok;
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_addr = 5'd7;
    @(posedge clk); #1;
    start = 0;
    wait_done(lat, bok);
    n_vec++;
    if (lat !== 33 || !bok || result !== 32'd14 || wb_addr !== 5'd3) begin
      n_err++;
      $display("FAIL ignore_busy_start: got lat=%0d busy_ok=%0b res=%h addr=%0d, expected lat=33 busy_ok=1 res=0000000e addr=3",
               lat, bok, result, wb_addr);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok; logic [31:0] a, b, exp;
    a = $urandom; b = $urandom;
    exp = model(3'd3, a, b);
    issue(3'd3, a, b, 5'd11);
    wait_done(lat, bok);
    n_vec++;
    if (lat !== 33 || result !== exp) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d res=%h, expected lat=33 res=%h", lat, result, exp);
    end
    a = $urandom; b = 32'($urandom_range(1, 1000));
    exp = model(3'd5, a, b);
    issue(3'd5, a, b, 5'd12);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got done=%b busy=%b, expected done=0 busy=1", done, busy);
    end
    wait_done(lat, bok);
    n_vec++;
    if (lat !== 33 || !bok || result !== exp || wb_addr !== 5'd12 || wb_en !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d busy_ok=%0b res=%h addr=%0d en=%b, expected lat=33 busy_ok=1 res=%h addr=12 en=1",
               lat, bok, result, wb_addr, wb_en, exp);
    end
  endtask

  task automatic test_rd_zero();
    int lat; bit bok; logic [31:0] res, a, b, exp; logic [4:0] wa; logic we;
    a = $urandom; b = $urandom;
    exp = model(3'd0, a, b);
    exec(3'd0, a, b, 5'd0, lat, bok, res, wa, we);
    n_vec++;
    if (lat !== 33 || we !== 1'b0 || res !== exp || wa !== 5'd0) begin
      n_err++;
      $display("FAIL rd_zero: got lat=%0d en=%b res=%h addr=%0d, expected lat=33 en=0 res=%h addr=0", lat, we, res, wa, exp);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    repeat (10) @(posedge clk);
    #2 reset = 1;
    #1;
    n_vec++;
    if ({busy, done, wb_en, result, wb_addr} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b wb_en=%b result=%h wb_addr=%0d, expected all zero",
               busy, done, wb_en, result, wb_addr);
    end
    @(negedge clk) reset = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done || wb_en || busy) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_wb: got %0d active cycles after reset, expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy_start();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
